// File: rtl/csi_rx_packet_handler_mvc_if.sv
`default_nettype none
// ============================================================================
// Interface : csi_rx_packet_handler_mvc_if
// Combined-word input stream, link feedback and payload output stream.
// Revision  : 1.0
// ============================================================================
interface csi_rx_packet_handler_mvc_if;
  logic [31:0] data;
  logic        data_enable;
  logic        data_frame;
  logic        lp_detect;
  logic        sync_wait;
  logic        packet_done;
  logic [31:0] payload;
  logic        payload_enable;
  logic [3:0]  payload_bytes;
  logic        payload_last;
  logic [1:0]  payload_vc;

  modport master (
    output data, data_enable, data_frame, lp_detect,
    input  sync_wait, packet_done, payload, payload_enable, payload_bytes,
           payload_last, payload_vc
  );

  modport slave (
    input  data, data_enable, data_frame, lp_detect,
    output sync_wait, packet_done, payload, payload_enable, payload_bytes,
           payload_last, payload_vc
  );
endinterface
`default_nettype wire

// File: rtl/csi_rx_packet_handler_mvc.sv
`default_nettype none
// ============================================================================
// Module   : csi_rx_packet_handler_mvc
// CSI-2 header/ECC parser, video payload streamer with CRC-16, per-VC frames.
// Revision : 1.0
// ============================================================================
module csi_rx_packet_handler_mvc #(
  parameter int          NUM_VC   = 4,
  parameter logic [5:0]  FS_DT    = 6'h00,
  parameter logic [5:0]  FE_DT    = 6'h01,
  parameter logic [5:0]  VIDEO_DT = 6'h2A,
  parameter logic [15:0] MAX_LEN  = 16'd8192
) (
  input  wire logic                   clock,
  input  wire logic                   reset,
  input  wire logic                   enable,
  csi_rx_packet_handler_mvc_if.slave  bus,
  output logic [NUM_VC-1:0]           in_frame,
  output logic                        in_line,
  output logic [NUM_VC-1:0]           vsync,
  output logic                        ecc_error,
  output logic                        crc_valid,
  output logic                        crc_error
);

  // Parity row masks over header bits [23:0], P5 in the top slice, P0 at the bottom
  localparam logic [143:0] ECC_MASKS = {24'hEFFC00, 24'hDF03F0, 24'hB8E38E,
                                        24'h749A6D, 24'hF2555B, 24'hF12CB7};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_SKIP    = 2'd2
  } state_t;

  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    for (int k = 0; k < 6; k++) p[k] = ^(d & ECC_MASKS[24*k +: 24]);
    return p;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
    logic [15:0] c;
    c = crc_in;
    for (int k = 0; k < 8; k++) begin
      if (c[0] ^ b[k]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [16:0]         rem_q, rem_d;
  logic [15:0]         crc_q, crc_d;
  logic [15:0]         rx_crc_q, rx_crc_d;
  logic [1:0]          vc_q, vc_d;
  logic [NUM_VC-1:0]   in_frame_q, in_frame_d;
  logic [NUM_VC-1:0]   vsync_q, vsync_d;
  logic [31:0]         payload_q, payload_d;
  logic                payload_enable_q, payload_enable_d;
  logic [3:0]          payload_bytes_q, payload_bytes_d;
  logic                payload_last_q, payload_last_d;
  logic                in_line_q, in_line_d;
  logic                ecc_error_q, ecc_error_d;
  logic                packet_done_q, packet_done_d;
  logic                crc_valid_q, crc_valid_d;
  logic                crc_error_q, crc_error_d;

  logic [15:0]         hdr_wc;
  logic [1:0]          hdr_vc;
  logic [5:0]          hdr_dt;
  logic                hdr_ok;
  logic                vc_ok;
  logic [15:0]         crc_w;
  logic [15:0]         rx_w;
  logic [3:0]          mask_w;
  logic [16:0]         rem_step;

  always_comb begin
    state_d          = state_q;
    rem_d            = rem_q;
    crc_d            = crc_q;
    rx_crc_d         = rx_crc_q;
    vc_d             = vc_q;
    in_frame_d       = in_frame_q;
    payload_d        = payload_q;
    payload_enable_d = 1'b0;
    payload_bytes_d  = 4'h0;
    payload_last_d   = 1'b0;
    vsync_d          = '0;
    ecc_error_d      = 1'b0;
    packet_done_d    = 1'b0;
    crc_valid_d      = 1'b0;
    crc_error_d      = 1'b0;
    in_line_d        = in_line_q & ~payload_last_q;

    hdr_wc = bus.data[23:8];
    hdr_vc = bus.data[7:6];
    hdr_dt = bus.data[5:0];
    hdr_ok = (ecc6(bus.data[23:0]) == bus.data[29:24]) && (bus.data[31:30] == 2'b00);
    vc_ok  = 32'(hdr_vc) < NUM_VC;

    // Classify each byte lane: payload while i < rem-2, CRC while i < rem
    crc_w  = crc_q;
    rx_w   = rx_crc_q;
    mask_w = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (17'(i + 2) < rem_q) begin
        mask_w[i] = 1'b1;
        crc_w     = crc16_byte(crc_w, bus.data[8*i +: 8]);
      end else if (17'(i) < rem_q) begin
        if (17'(i + 2) == rem_q) rx_w[7:0]  = bus.data[8*i +: 8];
        else                     rx_w[15:8] = bus.data[8*i +: 8];
      end
    end
    rem_step = (rem_q > 17'd4) ? (rem_q - 17'd4) : 17'd0;

    if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.data_enable && !bus.lp_detect) begin
            packet_done_d = 1'b1;
            if (!hdr_ok || (hdr_dt >= 6'h10 && hdr_wc > MAX_LEN)) begin
              ecc_error_d = 1'b1;
            end else if (hdr_dt < 6'h10) begin
              for (int v = 0; v < NUM_VC; v++) begin
                if (32'(hdr_vc) == v) begin
                  if (hdr_dt == FS_DT) begin
                    vsync_d[v]    = 1'b1;
                    in_frame_d[v] = 1'b1;
                  end else if (hdr_dt == FE_DT) begin
                    in_frame_d[v] = 1'b0;
                  end
                end
              end
            end else begin
              packet_done_d = 1'b0;
              rem_d         = {1'b0, hdr_wc} + 17'd2;
              crc_d         = 16'hFFFF;
              rx_crc_d      = 16'h0000;
              vc_d          = hdr_vc;
              state_d       = (hdr_dt == VIDEO_DT && vc_ok) ? ST_PAYLOAD : ST_SKIP;
            end
          end
        end
        ST_PAYLOAD, ST_SKIP: begin
          if (bus.lp_detect) begin
            state_d       = ST_IDLE;
            packet_done_d = 1'b1;
            in_line_d     = 1'b0;
          end else if (rem_q == 17'd0) begin
            state_d       = ST_IDLE;
            packet_done_d = 1'b1;
            if (state_q == ST_PAYLOAD) begin
              crc_valid_d = 1'b1;
              crc_error_d = (crc_q != rx_crc_q);
            end
          end else if (!bus.data_frame) begin
            state_d       = ST_IDLE;
            packet_done_d = 1'b1;
            in_line_d     = 1'b0;
          end else if (bus.data_enable) begin
            rem_d = rem_step;
            if (state_q == ST_PAYLOAD) begin
              crc_d            = crc_w;
              rx_crc_d         = rx_w;
              payload_d        = bus.data;
              payload_bytes_d  = mask_w;
              payload_enable_d = |mask_w;
              payload_last_d   = (|mask_w) && (rem_q <= 17'd6);
              if (|mask_w) in_line_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      rem_q            <= '0;
      crc_q            <= '0;
      rx_crc_q         <= '0;
      vc_q             <= '0;
      in_frame_q       <= '0;
      vsync_q          <= '0;
      payload_q        <= '0;
      payload_enable_q <= 1'b0;
      payload_bytes_q  <= '0;
      payload_last_q   <= 1'b0;
      in_line_q        <= 1'b0;
      ecc_error_q      <= 1'b0;
      packet_done_q    <= 1'b0;
      crc_valid_q      <= 1'b0;
      crc_error_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      rem_q            <= rem_d;
      crc_q            <= crc_d;
      rx_crc_q         <= rx_crc_d;
      vc_q             <= vc_d;
      in_frame_q       <= in_frame_d;
      vsync_q          <= vsync_d;
      payload_q        <= payload_d;
      payload_enable_q <= payload_enable_d;
      payload_bytes_q  <= payload_bytes_d;
      payload_last_q   <= payload_last_d;
      in_line_q        <= in_line_d;
      ecc_error_q      <= ecc_error_d;
      packet_done_q    <= packet_done_d;
      crc_valid_q      <= crc_valid_d;
      crc_error_q      <= crc_error_d;
    end
  end

  assign bus.sync_wait      = (state_q == ST_IDLE) & ~reset;
  assign bus.packet_done    = packet_done_q;
  assign bus.payload        = payload_q;
  assign bus.payload_enable = payload_enable_q;
  assign bus.payload_bytes  = payload_bytes_q;
  assign bus.payload_last   = payload_last_q;
  assign bus.payload_vc     = vc_q;
  assign in_frame           = in_frame_q;
  assign in_line            = in_line_q;
  assign vsync              = vsync_q;
  assign ecc_error          = ecc_error_q;
  assign crc_valid          = crc_valid_q;
  assign crc_error          = crc_error_q;

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_packet_handler_mvc.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi_rx_packet_handler_mvc
// Directed packets into two handler instances (NUM_VC=4 and NUM_VC=2).
// Revision : 1.0
// ============================================================================
module tb_csi_rx_packet_handler_mvc;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  always #5 clock = ~clock;

  csi_rx_packet_handler_mvc_if bus ();
  csi_rx_packet_handler_mvc_if bus2 ();

  logic [3:0] in_frame, vsync;
  logic       in_line, ecc_error, crc_valid, crc_error;
  logic [1:0] in_frame2, vsync2;
  logic       in_line2, ecc_error2, crc_valid2, crc_error2;

  csi_rx_packet_handler_mvc #(.NUM_VC(4)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .bus(bus),
    .in_frame(in_frame), .in_line(in_line), .vsync(vsync),
    .ecc_error(ecc_error), .crc_valid(crc_valid), .crc_error(crc_error)
  );

  csi_rx_packet_handler_mvc #(.NUM_VC(2)) u_dut2 (
    .clock(clock), .reset(reset), .enable(enable), .bus(bus2),
    .in_frame(in_frame2), .in_line(in_line2), .vsync(vsync2),
    .ecc_error(ecc_error2), .crc_valid(crc_valid2), .crc_error(crc_error2)
  );

  assign bus2.data        = bus.data;
  assign bus2.data_enable = bus.data_enable;
  assign bus2.data_frame  = bus.data_frame;
  assign bus2.lp_detect   = bus.lp_detect;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Column code of each header bit in the CSI-2 Hamming table
  function automatic logic [5:0] ecc_ref(input logic [23:0] d);
    logic [5:0] col [24];
    logic [5:0] p;
    col = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
            6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
            6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    p = 6'h00;
    for (int k = 0; k < 24; k++) if (d[k]) p = p ^ col[k];
    return p;
  endfunction

  function automatic logic [31:0] hdr(input logic [7:0] di, input logic [15:0] wc);
    logic [23:0] d;
    d = {wc, di};
    return {2'b00, ecc_ref(d), d};
  endfunction

  function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in;
    for (int k = 0; k < 8; k++) c = (c[0] ^ b[k]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  // Output monitors
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] pl_data [0:127];
  logic [3:0]  pl_bytes [0:127];
  logic        pl_last [0:127];
  logic [1:0]  pl_vc [0:127];
  logic        pl_inl [0:127];
  int          pl_cyc [0:127];
  int n_pe = 0, n_pd = 0, n_ecc = 0, n_crcv = 0, n_vs = 0;
  int crcv_cyc = 0;
  logic crc_err_last = 1'b0, crcv_inl = 1'b0;
  logic [3:0] vs_last = 4'h0;
  int n2_pe = 0, n2_pd = 0, n2_ecc = 0, n2_crcv = 0, pd2_cyc = 0;
  logic [1:0] vs2_last = 2'b00;

  always @(negedge clock) begin
    if (bus.payload_enable === 1'b1) begin
      if (n_pe < 128) begin
        pl_data[n_pe]  <= bus.payload;
        pl_bytes[n_pe] <= bus.payload_bytes;
        pl_last[n_pe]  <= bus.payload_last;
        pl_vc[n_pe]    <= bus.payload_vc;
        pl_inl[n_pe]   <= in_line;
        pl_cyc[n_pe]   <= cyc;
      end
      n_pe <= n_pe + 1;
    end
    if (bus.packet_done === 1'b1) n_pd <= n_pd + 1;
    if (ecc_error === 1'b1) n_ecc <= n_ecc + 1;
    if (crc_valid === 1'b1) begin
      n_crcv       <= n_crcv + 1;
      crc_err_last <= crc_error;
      crcv_cyc     <= cyc;
      crcv_inl     <= in_line;
    end
    if (vsync != 4'h0) begin
      n_vs    <= n_vs + 1;
      vs_last <= vsync;
    end
    if (bus2.payload_enable === 1'b1) n2_pe <= n2_pe + 1;
    if (bus2.packet_done === 1'b1) begin
      n2_pd   <= n2_pd + 1;
      pd2_cyc <= cyc;
    end
    if (ecc_error2 === 1'b1) n2_ecc <= n2_ecc + 1;
    if (crc_valid2 === 1'b1) n2_crcv <= n2_crcv + 1;
    if (vsync2 != 2'b00) vs2_last <= vsync2;
  end

  int last_put = 0;
  logic [7:0] sb [0:300];

  task automatic drive(input logic [31:0] w, input logic de, input logic fr);
    @(negedge clock);
    bus.data        = w;
    bus.data_enable = de;
    bus.data_frame  = fr;
  endtask

  task automatic gap(input int n);
    repeat (n) drive(32'h0, 1'b0, 1'b0);
  endtask

  // Long packet: bytes 1,2,3..., correct CRC; bad_idx >= 0 corrupts that byte after CRC is taken
  task automatic send_long(input logic [7:0] di, input int wc, input int bad_idx);
    logic [15:0] c;
    logic [31:0] w;
    int nb;
    c = 16'hFFFF;
    for (int i = 0; i < wc; i++) begin
      sb[i] = 8'(i + 1);
      c = crc_ref(c, sb[i]);
    end
    if (bad_idx >= 0) sb[bad_idx] = sb[bad_idx] ^ 8'h10;
    sb[wc]     = c[7:0];
    sb[wc + 1] = c[15:8];
    nb = wc + 2;
    drive(hdr(di, 16'(wc)), 1'b1, 1'b1);
    for (int i = 0; i < nb; i += 4) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) if (i + j < nb) w[8*j +: 8] = sb[i + j];
      drive(w, 1'b1, 1'b1);
      last_put = cyc;
    end
  endtask

  int b_pe, b_pd, b_ecc, b_crcv, b_vs, b2_pe, b2_pd, b2_ecc, b2_crcv;

  task automatic snap();
    b_pe = n_pe; b_pd = n_pd; b_ecc = n_ecc; b_crcv = n_crcv; b_vs = n_vs;
    b2_pe = n2_pe; b2_pd = n2_pd; b2_ecc = n2_ecc; b2_crcv = n2_crcv;
  endtask

  initial begin
    reset           = 1'b1;
    enable          = 1'b1;
    bus.data        = 32'h0;
    bus.data_enable = 1'b0;
    bus.data_frame  = 1'b0;
    bus.lp_detect   = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("sync_wait_in_reset", 32'(bus.sync_wait), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_sync_wait", 32'(bus.sync_wait), 32'd1);
    check_eq("rst_outputs", {bus.payload_enable, bus.packet_done, in_line, crc_valid, ecc_error},
             32'd0);
    check_eq("rst_in_frame", 32'(in_frame), 32'd0);

    // Frame start on VC1 (hand-computed ECC 0x16)
    snap();
    drive(32'h16000040, 1'b1, 1'b1);
    gap(3);
    check_eq("fs_vsync_pulses", n_vs - b_vs, 1);
    check_eq("fs_vsync_val", 32'(vs_last), 32'h2);
    check_eq("fs_in_frame", 32'(in_frame), 32'h2);
    check_eq("fs_packet_done", n_pd - b_pd, 1);
    check_eq("fs_in_frame_nvc2", 32'(in_frame2), 32'h2);
    check_eq("fs_vsync_nvc2", 32'(vs2_last), 32'h2);

    // Video long packet, WC=6, good CRC
    snap();
    send_long(8'h2A, 6, -1);
    gap(4);
    check_eq("lp_words", n_pe - b_pe, 2);
    check_eq("lp_w0_data", pl_data[b_pe], 32'h04030201);
    check_eq("lp_w0_bytes", 32'(pl_bytes[b_pe]), 32'hF);
    check_eq("lp_w0_last", 32'(pl_last[b_pe]), 32'd0);
    check_eq("lp_w0_vc", 32'(pl_vc[b_pe]), 32'd0);
    check_eq("lp_w0_in_line", 32'(pl_inl[b_pe]), 32'd1);
    check_eq("lp_w1_data", pl_data[b_pe + 1] & 32'h0000FFFF, 32'h00000605);
    check_eq("lp_w1_bytes", 32'(pl_bytes[b_pe + 1]), 32'h3);
    check_eq("lp_w1_last", 32'(pl_last[b_pe + 1]), 32'd1);
    check_eq("lp_w1_latency", pl_cyc[b_pe + 1], last_put + 1);
    check_eq("lp_crc_valid", n_crcv - b_crcv, 1);
    check_eq("lp_crc_error", 32'(crc_err_last), 32'd0);
    check_eq("lp_crc_timing", crcv_cyc, pl_cyc[b_pe + 1] + 1);
    check_eq("lp_in_line_fall", 32'(crcv_inl), 32'd0);
    check_eq("lp_packet_done", n_pd - b_pd, 1);
    check_eq("lp_sync_wait", 32'(bus.sync_wait), 32'd1);

    // Same packet with payload byte 2 corrupted
    snap();
    send_long(8'h2A, 6, 2);
    gap(4);
    check_eq("bad_words", n_pe - b_pe, 2);
    check_eq("bad_w0_data", pl_data[b_pe], 32'h04130201);
    check_eq("bad_masks", {28'h0, pl_bytes[b_pe + 1]}, 32'h3);
    check_eq("bad_last", {30'h0, pl_last[b_pe], pl_last[b_pe + 1]}, 32'h1);
    check_eq("bad_crc_valid", n_crcv - b_crcv, 1);
    check_eq("bad_crc_error", 32'(crc_err_last), 32'd1);

    // FS VC1 with a flipped header bit, then a good FE VC1
    snap();
    drive(32'h16000140, 1'b1, 1'b1);
    gap(3);
    check_eq("ecc_error_pulse", n_ecc - b_ecc, 1);
    check_eq("ecc_no_vsync", n_vs - b_vs, 0);
    check_eq("ecc_in_frame_kept", 32'(in_frame), 32'h2);
    check_eq("ecc_packet_done", n_pd - b_pd, 1);
    check_eq("ecc_no_payload", n_pe - b_pe, 0);
    snap();
    drive(hdr(8'h41, 16'd0), 1'b1, 1'b1);
    gap(3);
    check_eq("fe_in_frame", 32'(in_frame), 32'h0);
    check_eq("fe_no_ecc_error", n_ecc - b_ecc, 0);
    check_eq("fe_packet_done", n_pd - b_pd, 1);

    // WC one above MAX_LEN is a header error
    snap();
    drive(hdr(8'h2A, 16'd8193), 1'b1, 1'b1);
    gap(3);
    check_eq("maxlen_ecc_error", n_ecc - b_ecc, 1);
    check_eq("maxlen_nvc2_ecc_error", n2_ecc - b2_ecc, 1);
    check_eq("maxlen_sync_wait", 32'(bus.sync_wait), 32'd1);

    // VC3, WC=8: skipped by NUM_VC=2, streamed by NUM_VC=4
    snap();
    send_long(8'hEA, 8, -1);
    gap(4);
    check_eq("skip_no_payload", n2_pe - b2_pe, 0);
    check_eq("skip_packet_done", n2_pd - b2_pd, 1);
    check_eq("skip_done_timing", pd2_cyc, last_put + 2);
    check_eq("skip_no_crc_valid", n2_crcv - b2_crcv, 0);
    check_eq("skip_in_line", 32'(in_line2), 32'd0);
    check_eq("vc3_words", n_pe - b_pe, 2);
    check_eq("vc3_payload_vc", 32'(pl_vc[b_pe]), 32'd3);
    check_eq("vc3_crc_error", 32'(crc_err_last), 32'd0);

    // lp_detect after 5 payload words of a WC=64 packet
    snap();
    drive(hdr(8'h2A, 16'd64), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(32'hA5A50000 + 32'(i), 1'b1, 1'b1);
    @(negedge clock);
    bus.data_enable = 1'b0;
    bus.lp_detect   = 1'b1;
    check_eq("abort_in_line_before", 32'(in_line), 32'd1);
    @(negedge clock);
    check_eq("abort_packet_done", 32'(bus.packet_done), 32'd1);
    check_eq("abort_in_line", 32'(in_line), 32'd0);
    check_eq("abort_sync_wait", 32'(bus.sync_wait), 32'd1);
    bus.lp_detect  = 1'b0;
    bus.data_frame = 1'b0;
    gap(4);
    check_eq("abort_no_crc_valid", n_crcv - b_crcv, 0);
    check_eq("abort_words", n_pe - b_pe, 5);
    check_eq("abort_done_count", n_pd - b_pd, 1);

    // enable low ignores a FS header; enable high accepts it
    snap();
    @(negedge clock);
    enable = 1'b0;
    drive(32'h00000000, 1'b1, 1'b1);
    gap(3);
    check_eq("dis_no_vsync", n_vs - b_vs, 0);
    check_eq("dis_no_done", n_pd - b_pd, 0);
    check_eq("dis_in_frame", 32'(in_frame), 32'h0);
    enable = 1'b1;
    snap();
    drive(32'h00000000, 1'b1, 1'b1);
    gap(3);
    check_eq("en_vsync", 32'(vs_last), 32'h1);
    check_eq("en_in_frame", 32'(in_frame), 32'h1);

    // reset in the middle of a packet
    drive(hdr(8'h2A, 16'd64), 1'b1, 1'b1);
    drive(32'h11223344, 1'b1, 1'b1);
    drive(32'h55667788, 1'b1, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_in_frame", 32'(in_frame), 32'h0);
    check_eq("mid_rst_outputs", {bus.payload_enable, in_line, bus.sync_wait}, 32'd0);
    reset = 1'b0;
    bus.data_enable = 1'b0;
    bus.data_frame  = 1'b0;
    @(negedge clock);
    check_eq("mid_rst_sync_wait", 32'(bus.sync_wait), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
